// File: rtl/fp_align_4in_if.sv
`default_nettype none
// ============================================================================
//  Module   : fp_align_4in_if
//  Purpose  : Handshake and data bundle for the 4-input FP alignment stage.
//             The input side carries the four {sign, exp, mant} operands.
//             The output side carries the aligned two's-complement lanes and
//             their common exponent.
//  Ports    : in_valid / in_ready / ops                 (operand side)
//             out_valid / out_ready / manOffset / maxExp (aligned side)
//  Modports : master - producer of operands / consumer of aligned sets
//             slave  - the alignment block itself
//  Revision : 1.0  initial release
// ============================================================================
interface fp_align_4in_if #(
    parameter int expWidth   = 4,
    parameter int sigWidth   = 4,
    parameter int low_expand = 2
);
    localparam int L = 1 + expWidth + sigWidth;
    localparam int W = sigWidth + 4 + low_expand;

    logic                in_valid;
    logic                in_ready;
    logic [4*L-1:0]      ops;
    logic                out_valid;
    logic                out_ready;
    logic [4*W-1:0]      manOffset;
    logic [expWidth-1:0] maxExp;

    modport master (
        output in_valid, ops, out_ready,
        input  in_ready, out_valid, manOffset, maxExp
    );

    modport slave (
        input  in_valid, ops, out_ready,
        output in_ready, out_valid, manOffset, maxExp
    );
endinterface
`default_nettype wire

// File: rtl/fp_align_4in.sv
`default_nettype none
// ============================================================================
//  Module   : fp_align_4in
//  Purpose  : Front end of the 4-input low-precision FP accumulate path.
//             Stage 1 captures the four operands and finds the largest
//             exponent among the non-zero ones. Stage 2 right-aligns every
//             significand to that exponent, negates the lanes that carry a
//             set sign bit, and packs the results into manOffset.
//  Ports    : clk    - clock, rising edge
//             rst_n  - asynchronous active-low reset
//             bus    - fp_align_4in_if.slave: in_valid/in_ready/ops,
//                      out_valid/out_ready/manOffset/maxExp
//  Options  : FP_ALIGN_ROUND_EN - when defined, the alignment shift rounds
//             half-up on the magnitude. When undefined, the shift truncates.
//  Revision : 1.0  initial release
// ============================================================================
module fp_align_4in #(
    parameter int expWidth   = 4,
    parameter int sigWidth   = 4,
    parameter int low_expand = 2
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    fp_align_4in_if.slave  bus
);
    localparam int L = 1 + expWidth + sigWidth;
    localparam int W = sigWidth + 4 + low_expand;

    // Stage 1 state
    logic                s1_valid_q, s1_valid_d;
    logic [4*L-1:0]      ops_q, ops_d;
    logic [expWidth-1:0] s1_maxexp_q, s1_maxexp_d;
    // Stage 2 (output) state
    logic                out_valid_q, out_valid_d;
    logic [4*W-1:0]      man_q, man_d;
    logic [expWidth-1:0] maxexp_q, maxexp_d;

    logic                w_s2_ready;
    logic                w_in_ready;
    logic [expWidth-1:0] w_in_exp [4];
    logic [expWidth-1:0] w_maxexp_in;
    logic [4*W-1:0]      w_lane;

    // Each stage may load when it is empty or when its content leaves this cycle.
    assign w_s2_ready = !out_valid_q || bus.out_ready;
    assign w_in_ready = !s1_valid_q || w_s2_ready;

    // ---------------- Stage 1: max exponent over non-zero operands ----------
    for (genvar g = 0; g < 4; g++) begin : g_inexp
        assign w_in_exp[g] = bus.ops[g*L+sigWidth +: expWidth];
    end

    always_comb begin
        w_maxexp_in = '0;
        for (int i = 0; i < 4; i++) begin
            // exp==0 marks a zero operand, which must not steer the common exponent.
            if ((w_in_exp[i] != '0) && (w_in_exp[i] > w_maxexp_in)) begin
                w_maxexp_in = w_in_exp[i];
            end
        end
    end

    // ---------------- Stage 2: per-lane alignment ---------------------------
    for (genvar g = 0; g < 4; g++) begin : g_lane
        logic                w_sign;
        logic [expWidth-1:0] w_exp;
        logic [expWidth-1:0] w_d;
        logic [sigWidth-1:0] w_mant;
        logic [W-1:0]        w_mag;
        logic [W-1:0]        w_shr;
        logic [W-1:0]        w_mag_f;

        assign w_sign = ops_q[g*L+L-1];
        assign w_exp  = ops_q[g*L+sigWidth +: expWidth];
        assign w_mant = ops_q[g*L +: sigWidth];
        assign w_d    = s1_maxexp_q - w_exp;
        // Hidden bit lands at bit sigWidth+low_expand; guard bits sit below the mantissa.
        assign w_mag  = W'({1'b1, w_mant}) << low_expand;
        assign w_shr  = (32'(w_d) >= W) ? '0 : (w_mag >> w_d);

`ifdef FP_ALIGN_ROUND_EN
        logic [W-1:0] w_rmask;
        logic         w_rbit;
        // The round bit is the last bit shifted out: bit (d-1) of the pre-shift magnitude.
        assign w_rmask = W'(1) << (w_d - expWidth'(1));
        assign w_rbit  = (w_d != '0) && (32'(w_d) < W) && (|(w_mag & w_rmask));
        assign w_mag_f = w_shr + W'(w_rbit);
`else
        assign w_mag_f = w_shr;
`endif

        assign w_lane[g*W +: W] = (w_exp == '0) ? '0 :
                                  (w_sign ? (-w_mag_f) : w_mag_f);
    end

    // ---------------- Pipeline control --------------------------------------
    always_comb begin
        s1_valid_d  = s1_valid_q;
        ops_d       = ops_q;
        s1_maxexp_d = s1_maxexp_q;
        out_valid_d = out_valid_q;
        man_d       = man_q;
        maxexp_d    = maxexp_q;

        if (w_in_ready) begin
            s1_valid_d = bus.in_valid;
            if (bus.in_valid) begin
                ops_d       = bus.ops;
                s1_maxexp_d = w_maxexp_in;
            end
        end

        if (w_s2_ready) begin
            out_valid_d = s1_valid_q;
            // A bubble keeps the previous data. Only out_valid drops.
            if (s1_valid_q) begin
                man_d    = w_lane;
                maxexp_d = s1_maxexp_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            ops_q       <= '0;
            s1_maxexp_q <= '0;
            out_valid_q <= 1'b0;
            man_q       <= '0;
            maxexp_q    <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            ops_q       <= ops_d;
            s1_maxexp_q <= s1_maxexp_d;
            out_valid_q <= out_valid_d;
            man_q       <= man_d;
            maxexp_q    <= maxexp_d;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.manOffset = man_q;
    assign bus.maxExp    = maxexp_q;

endmodule
`default_nettype wire

// File: tb/tb_fp_align_4in.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fp_align_4in
//  Purpose  : Self-checking bench for fp_align_4in. It runs directed vectors,
//             a backpressure sequence, a reset in mid-flight, and random
//             traffic compared against an arithmetic reference model.
//  Options  : FP_ALIGN_ROUND_EN selects the rounding expectations.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fp_align_4in;
    logic clk;
    logic rst_n;

    fp_align_4in_if #(.expWidth(4), .sigWidth(4), .low_expand(2)) bif ();

    fp_align_4in #(.expWidth(4), .sigWidth(4), .low_expand(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_recv   = 0;

    logic [43:0] sb [$];
    bit          stalled;
    logic [43:0] held;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // The reference model works from the number rules with integer arithmetic.
    function automatic logic [43:0] model(input logic [35:0] o);
        int e [4];
        int m [4];
        int s [4];
        int mx, d, mag, v;
        logic [39:0] man;
        mx = 0;
        man = '0;
        for (int i = 0; i < 4; i++) begin
            s[i] = int'(o[i*9+8]);
            e[i] = int'(o[i*9+4 +: 4]);
            m[i] = int'(o[i*9 +: 4]);
            if (e[i] != 0 && e[i] > mx) mx = e[i];
        end
        for (int i = 0; i < 4; i++) begin
            v = 0;
            if (e[i] != 0) begin
                mag = (16 + m[i]) * 4;
                d = mx - e[i];
                if (d < 10) begin
                    v = mag / (1 << d);
`ifdef FP_ALIGN_ROUND_EN
                    if (d >= 1) v = v + ((mag / (1 << (d - 1))) % 2);
`endif
                end
                if (s[i] != 0) v = -v;
            end
            man[i*10 +: 10] = 10'(v);
        end
        return {man, 4'(mx)};
    endfunction

    function automatic bit sum_fits(input logic [39:0] man);
        int t;
        t = 0;
        for (int i = 0; i < 4; i++) t = t + int'($signed(man[i*10 +: 10]));
        return (t >= -512) && (t <= 511);
    endfunction

    // Monitor: the scoreboard checks order, data, the lane sum, and stability under stall.
    always @(negedge clk) begin
        if (!rst_n) begin
            stalled = 1'b0;
        end else begin
            if (stalled)
                chk("stall_hold", {19'd0, bif.out_valid, bif.manOffset, bif.maxExp}, {19'd0, 1'b1, held});
            stalled = 1'b0;
            if (bif.in_valid && bif.in_ready) sb.push_back(model(bif.ops));
            if (bif.out_valid) begin
                if (bif.out_ready) begin
                    if (sb.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_out: got 0x%0h expected no output", {bif.manOffset, bif.maxExp});
                    end else begin
                        chk("sb_data", {20'd0, bif.manOffset, bif.maxExp}, {20'd0, sb.pop_front()});
                        chk("sum_fits", {63'd0, sum_fits(bif.manOffset)}, 64'd1);
                        n_recv++;
                    end
                end else begin
                    stalled = 1'b1;
                    held    = {bif.manOffset, bif.maxExp};
                end
            end
        end
    end

    typedef struct {
        logic [35:0] ops;
        logic [39:0] man_t;
        logic [39:0] man_r;
        logic [3:0]  maxe;
    } vec_t;

    vec_t vecs [7];

    function automatic logic [8:0] op(input logic s, input logic [3:0] e, input logic [3:0] m);
        return {s, e, m};
    endfunction

    task automatic run_vec(input int idx);
        int n;
        bit got;
        logic [39:0] em;
`ifdef FP_ALIGN_ROUND_EN
        em = vecs[idx].man_r;
`else
        em = vecs[idx].man_t;
`endif
        bif.ops = vecs[idx].ops;
        bif.in_valid = 1'b1;
        bif.out_ready = 1'b1;
        @(negedge clk);
        chk($sformatf("vec%0d_accept", idx), {63'd0, bif.in_ready}, 64'd1);
        @(posedge clk);
        #1 bif.in_valid = 1'b0;
        n = 0;
        got = 0;
        for (int k = 1; k <= 8 && !got; k++) begin
            @(negedge clk);
            if (bif.out_valid) begin
                got = 1;
                n = k;
            end
        end
        chk($sformatf("vec%0d_latency", idx), 64'(n), 64'd2);
        chk($sformatf("vec%0d_man", idx), {24'd0, bif.manOffset}, {24'd0, em});
        chk($sformatf("vec%0d_maxexp", idx), {60'd0, bif.maxExp}, {60'd0, vecs[idx].maxe});
        @(posedge clk);
        #1;
    endtask

    initial begin
        int sent, cyc, recv0;
        bit saw_low, pending;

        // Directed table: {op3, op2, op1, op0}, truncate result, rounded result, common exponent
        vecs[0] = '{{op(0,5,4'b1111), op(0,0,4'b0101), op(1,3,4'b0000), op(0,5,4'b1000)},
                    {10'h07C, 10'h000, 10'h3F0, 10'h060}, {10'h07C, 10'h000, 10'h3F0, 10'h060}, 4'd5};
        vecs[1] = '{{9'd0, 9'd0, op(0,1,4'b0011), op(0,5,4'b0000)},
                    {10'h000, 10'h000, 10'd4, 10'h040}, {10'h000, 10'h000, 10'd5, 10'h040}, 4'd5};
        vecs[2] = '{{op(0,1,4'b1111), op(0,1,4'b1111), op(0,1,4'b1111), op(0,8,4'b1111)},
                    {10'h000, 10'h000, 10'h000, 10'h07C}, {10'h001, 10'h001, 10'h001, 10'h07C}, 4'd8};
        vecs[3] = '{{op(1,0,4'b1111), op(0,0,4'b1010), op(1,0,4'b0001), op(0,0,4'b1111)},
                    40'd0, 40'd0, 4'd0};
        vecs[4] = '{{9'd0, 9'd0, op(0,4,4'b1010), op(1,7,4'b0101)},
                    {10'h000, 10'h000, 10'h00D, 10'h3AC}, {10'h000, 10'h000, 10'h00D, 10'h3AC}, 4'd7};
        vecs[5] = '{{9'd0, 9'd0, op(1,6,4'b0111), op(0,9,4'b0000)},
                    {10'h000, 10'h000, 10'h3F5, 10'h040}, {10'h000, 10'h000, 10'h3F4, 10'h040}, 4'd9};
        vecs[6] = '{{op(0,5,4'b1111), op(1,7,4'b1111), op(0,8,4'b1111), op(0,15,4'b0000)},
                    {10'h000, 10'h000, 10'h000, 10'h040}, {10'h000, 10'h000, 10'h001, 10'h040}, 4'd15};

        rst_n = 1'b0;
        bif.in_valid = 1'b0;
        bif.out_ready = 1'b0;
        bif.ops = '0;
        repeat (2) @(negedge clk);
        chk("reset_out_valid", {63'd0, bif.out_valid}, 64'd0);
        chk("reset_man", {24'd0, bif.manOffset}, 64'd0);
        chk("reset_maxexp", {60'd0, bif.maxExp}, 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("reset_in_ready", {63'd0, bif.in_ready}, 64'd1);
        @(posedge clk);
        #1;

        for (int i = 0; i < 7; i++) run_vec(i);

        // Backpressure: stream 6 sets; out_ready stays low in cycles 3..7.
        recv0 = n_recv;
        sent = 0;
        saw_low = 0;
        for (cyc = 0; cyc < 40; cyc++) begin
            bif.out_ready = !(cyc >= 3 && cyc <= 7);
            bif.in_valid = (sent < 6);
            bif.ops = {$urandom, 4'($urandom)};
            @(negedge clk);
            if (!bif.in_ready) saw_low = 1;
            if (bif.in_valid && bif.in_ready) sent++;
            @(posedge clk);
            #1;
        end
        bif.in_valid = 1'b0;
        chk("bp_in_ready_fell", {63'd0, saw_low}, 64'd1);
        chk("bp_all_sent", 64'(sent), 64'd6);
        chk("bp_all_received", 64'(n_recv - recv0), 64'd6);

        // Reset in mid-flight: two sets in the pipe, then an asynchronous reset.
        bif.out_ready = 1'b0;
        bif.in_valid = 1'b1;
        bif.ops = {op(0,3,4'b0001), op(0,4,4'b0010), op(1,5,4'b0011), op(0,6,4'b0100)};
        @(posedge clk);
        #1 bif.ops = {op(1,9,4'b1001), op(0,2,4'b0110), op(0,1,4'b0111), op(0,9,4'b0000)};
        @(posedge clk);
        #1 bif.in_valid = 1'b0;
        @(negedge clk);
        chk("rst_mid_pre_valid", {63'd0, bif.out_valid}, 64'd1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_out_valid", {63'd0, bif.out_valid}, 64'd0);
        chk("rst_mid_man", {24'd0, bif.manOffset}, 64'd0);
        sb.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        bif.out_ready = 1'b1;
        saw_low = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (bif.out_valid) saw_low = 1;
        end
        chk("rst_no_stale", {63'd0, saw_low}, 64'd0);
        @(posedge clk);
        #1;

        // Random traffic against the model.
        recv0 = n_recv;
        sent = 0;
        pending = 0;
        for (cyc = 0; cyc < 40000 && sent < 10000; cyc++) begin
            if (!pending) begin
                bif.in_valid = ($urandom_range(4) != 0);
                bif.ops = {$urandom, 4'($urandom)};
            end
            bif.out_ready = ($urandom_range(4) != 0);
            @(negedge clk);
            pending = bif.in_valid && !bif.in_ready;
            if (bif.in_valid && bif.in_ready) sent++;
            @(posedge clk);
            #1;
        end
        bif.in_valid = 1'b0;
        bif.out_ready = 1'b1;
        for (int k = 0; k < 20 && sb.size() != 0; k++) @(posedge clk);
        #1;
        chk("rand_sent", 64'(sent), 64'd10000);
        chk("rand_drained", 64'(sb.size()), 64'd0);
        chk("rand_received", 64'(n_recv - recv0), 64'd10000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/fp_align_4in.md
Name: fp_align_4in

Overview:
- Front end of the 4-input low-precision FP accumulate path: takes four FP products, finds the largest exponent, and right-aligns each significand to it.
- Converts each aligned significand to two's complement and packs the four lanes into the manOffset bus consumed by the 4-input adder/normaliser.
- Pipelined (2 stages) with valid/ready handshake on both sides.

Parameters:
- expWidth, 4, exponent field width per operand.
- sigWidth, 4, stored mantissa width (hidden bit implicit).
- low_expand, 2, guard bits below the aligned significand LSB.

Ports:
- clk  input  1  clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand set valid.
- in_ready  output  1  block can accept operands this cycle.
- ops  input  4*(1+expWidth+sigWidth)  four operands; op i at bits [(i+1)*L-1 : i*L], L=1+expWidth+sigWidth, each {sign, exp, mant}.
- out_valid  output  1  aligned set valid.
- out_ready  input  1  downstream accepts.
- manOffset  output  4*W  W=sigWidth+4+low_expand; lane i at [(i+1)*W-1 : i*W], signed two's complement.
- maxExp  output  expWidth  common exponent of the set (shared by all lanes).

Behaviour:
- Reset (async, rst_n=0): out_valid=0, manOffset=0, maxExp=0, both stage-valid flags 0; in_ready=1 after reset release.
- Zero operand: exp==0 → lane is 0; operand excluded from max-exponent search. If all four are zero: maxExp=0, all lanes 0.
- Stage 1 (capture): on in_valid&&in_ready register ops and compute maxExp = max of non-zero exponents (unsigned compare).
- Stage 2 (align): per lane d = maxExp - exp_i; mag = {1, mant} << low_expand (hidden bit at bit sigWidth+low_expand); mag >>= d, bits shifted below bit 0 discarded; d >= W → mag = 0. Lane = sign ? -mag : mag, W bits. The 3 top bits are headroom; the sum of four lanes never overflows W signed bits.
- Latency: 2 cycles from accepted input to out_valid when not stalled; throughput 1 set/cycle.
- Handshake: stage advances when the next stage is empty or draining. in_ready = !s1_valid || (!out_valid || out_ready). Output transfers on out_valid&&out_ready. While out_valid&&!out_ready, manOffset/maxExp hold stable and no set is dropped or duplicated.
- Simultaneous transfer out and accept in at full occupancy: allowed; order preserved.
- in_valid deasserted: bubbles propagate; out_valid drops accordingly.
- Reset mid-operation: all in-flight sets discarded; no output after release until a new set is accepted.

Optional Feature:
- FP_ALIGN_ROUND_EN defined: the alignment shift rounds half-up on magnitude; mag = (mag>>d) + bit(d-1) of pre-shift mag, for 1 <= d < W. Applied before negation. For d >= W, lane = 0. Lane may gain one LSB; headroom covers it.
- Undefined: pure truncation as above.

Test Plan:
- Basic align (FP_ALIGN_ROUND_EN undefined): op0={0,5,1000}, op1={1,3,0000}, op2={0,0,xxxx}, op3={0,5,1111} → 2 cycles later maxExp=5, manOffset lanes3..0 = 0x07C, 0x000, 0x3F0, 0x060.
- Rounding: op0={0,5,0000}, op1={0,1,0011}, others zero → lane1 = 4 without FP_ALIGN_ROUND_EN, 5 with it; lane0=0x040, maxExp=5.
- Large shift: exps {8,1,1,1}, mant 1111 → lanes1..3 = 0 (truncate); with FP_ALIGN_ROUND_EN each = 1. All exps 0 → lanes 0, maxExp 0.
- Backpressure: stream 6 sets with in_valid=1, hold out_ready=0 cycles 3–7 → in_ready falls once both stages are full; outputs stable while stalled; all 6 sets emerge in order, none lost or duplicated.
- Reset mid-op: accept 2 sets, assert rst_n=0 asynchronously mid-cycle → out_valid=0 immediately; after release no stale set appears.
- Random: 10k random sets compared against a reference model; sum of lanes fits W signed bits.
